// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single write port of the integer register file
//               between two writeback sources (A: ALU, B: load/multi-cycle).
//               Round-robin arbitration over valid/ready handshakes feeds a
//               registered write command. A per-register pending-write
//               scoreboard lets decode stall on RAW hazards.
//               Optional macro WB_TRACE_EN adds a simulation commit trace
//               with a registered source tag.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int XLEN       = 64,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   // Writeback source A
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [REG_ADDR_W-1:0] a_rd,
   input  logic [XLEN-1:0]       a_data,
   // Writeback source B
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [REG_ADDR_W-1:0] b_rd,
   input  logic [XLEN-1:0]       b_data,
   // Issue-side scoreboard update
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   // Decode-side hazard queries
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   // Register file write port
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]       rd_data
);

   localparam int c_num_regs = 2 ** REG_ADDR_W;

   // Arbitration state: 1 means B was granted most recently.
   logic                  r_last_b;

   // Grant decision
   logic                  w_a_ready;
   logic                  w_b_ready;
   logic                  w_accept;
   logic [REG_ADDR_W-1:0] w_grant_rd;
   logic [XLEN-1:0]       w_grant_data;
   logic                  w_commit;

   // Registered write command
   logic                  r_reg_write;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic [XLEN-1:0]       r_rd_data;

   // Scoreboard: x0 never has a pending write, so only 1..N-1 are stored.
   logic [c_num_regs-1:1] r_busy;
   logic [c_num_regs-1:0] w_busy_all;
   logic [c_num_regs-1:0] w_set_vec;
   logic [c_num_regs-1:0] w_clr_vec;

   // Round-robin grant: a lone requester always wins; under contention the
   // source that did not win last time gets the port. Readies are held low
   // during reset so nothing is accepted while state is being cleared.
   always_comb begin
      w_a_ready = 1'b0;
      w_b_ready = 1'b0;
      if (!rst) begin
         w_a_ready = a_valid && (!b_valid || r_last_b);
         w_b_ready = b_valid && (!a_valid || !r_last_b);
      end
   end

   assign a_ready = w_a_ready;
   assign b_ready = w_b_ready;

   // Select the granted source's command; the two readies are exclusive.
   always_comb begin
      w_accept     = w_a_ready || w_b_ready;
      w_grant_rd   = a_rd;
      w_grant_data = a_data;
      if (w_b_ready) begin
         w_grant_rd   = b_rd;
         w_grant_data = b_data;
      end
      // Writes to x0 complete the handshake but never reach the register file.
      w_commit = w_accept && (w_grant_rd != '0);
   end

   // Last-grant pointer moves on every accepted transfer, contended or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_b <= 1'b1;
      end else if (w_accept) begin
         r_last_b <= w_b_ready;
      end
   end

   // One-cycle output stage; address and data hold when nothing commits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reg_write <= 1'b0;
         r_rd_addr   <= '0;
         r_rd_data   <= '0;
      end else begin
         r_reg_write <= w_commit;
         if (w_commit) begin
            r_rd_addr <= w_grant_rd;
            r_rd_data <= w_grant_data;
         end
      end
   end

   assign reg_write = r_reg_write;
   assign rd_addr   = r_rd_addr;
   assign rd_data   = r_rd_data;

   // Decode the one-hot set (new producer issued) and clear (register file
   // commits this edge) vectors for the scoreboard.
   always_comb begin
      w_set_vec = '0;
      w_clr_vec = '0;
      if (issue_valid) begin
         w_set_vec[issue_rd] = 1'b1;
      end
      if (r_reg_write) begin
         w_clr_vec[r_rd_addr] = 1'b1;
      end
   end

   // Scoreboard update: set is applied after clear so a new producer for the
   // register being committed keeps it busy; bit 0 is dropped by the slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr_vec[c_num_regs-1:1]) | w_set_vec[c_num_regs-1:1];
      end
   end

   assign w_busy_all = {r_busy, 1'b0};
   assign rs1_busy   = w_busy_all[rs1_addr];
   assign rs2_busy   = w_busy_all[rs2_addr];

`ifdef WB_TRACE_EN
   // Source tag travels with the write command so the trace can name it.
   logic r_src_b;

   // Capture which source produced the command now in the output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_src_b <= 1'b0;
      end else if (w_commit) begin
         r_src_b <= w_b_ready;
      end
   end

   // Print each write on the edge the register file commits it.
   always @(posedge clk) begin
      if (!rst && r_reg_write) begin
         $display("WB commit: x%0d = %h (src %s)", r_rd_addr, r_rd_data,
                  r_src_b ? "B" : "A");
      end
   end
`else
   // No trace logic in the default build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter: directed scenario
//               tasks followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [4:0]  a_rd = '0;
   logic [63:0] a_data = '0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [4:0]  b_rd = '0;
   logic [63:0] b_data = '0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        reg_write;
   logic [4:0]  rd_addr;
   logic [63:0] rd_data;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   bit          m_busy [32];
   bit          m_last_b;
   bit          m_wr;
   logic [4:0]  m_addr;
   logic [63:0] m_data;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.XLEN(64), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   // Advance to 1 ns after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reset pulse; leaves the bench aligned 1 ns after an edge.
   task automatic do_reset;
      a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_last_b = 1'b1; m_wr = 1'b0; m_addr = '0; m_data = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd3; b_rd = 5'd4;
      #1;
      n_total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0)
         $display("FAIL reset_ready: a_ready=%b b_ready=%b, required 0 0", a_ready, b_ready);
      else n_pass++;
      n_total++;
      if (reg_write !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 64'd0)
         $display("FAIL reset_out: reg_write=%b rd_addr=%0d rd_data=%h, required 0 0 0",
                  reg_write, rd_addr, rd_data);
      else n_pass++;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         #1;
         n_total++;
         if (rs1_busy !== 1'b0)
            $display("FAIL reset_busy[%0d]: got %b, required 0", i, rs1_busy);
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_single;
      a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1234;
      #1;
      n_total++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0)
         $display("FAIL single_ready: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
      else n_pass++;
      tick();
      a_valid = 1'b0;
      n_total++;
      if (reg_write !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 64'h1234)
         $display("FAIL single_commit: reg_write=%b rd_addr=%0d rd_data=%h, required 1 5 1234",
                  reg_write, rd_addr, rd_data);
      else n_pass++;
      tick();
      n_total++;
      if (reg_write !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 64'h1234)
         $display("FAIL single_idle: reg_write=%b rd_addr=%0d rd_data=%h, required 0 5 1234 held",
                  reg_write, rd_addr, rd_data);
      else n_pass++;
   endtask

   task automatic test_contention;
      bit exp_b;
      do_reset();
      a_valid = 1'b1; a_rd = 5'd3; a_data = 64'hAAAA_0000_0000_0003;
      b_valid = 1'b1; b_rd = 5'd7; b_data = 64'hBBBB_0000_0000_0007;
      for (int i = 0; i < 4; i++) begin
         exp_b = (i % 2) == 1;
         #1;
         n_total++;
         if (a_ready !== !exp_b || b_ready !== exp_b)
            $display("FAIL contention_grant[%0d]: a_ready=%b b_ready=%b, required %b %b",
                     i, a_ready, b_ready, !exp_b, exp_b);
         else n_pass++;
         tick();
         if (i == 3) begin a_valid = 1'b0; b_valid = 1'b0; end
         n_total++;
         if (reg_write !== 1'b1 || rd_addr !== (exp_b ? 5'd7 : 5'd3) ||
             rd_data !== (exp_b ? b_data : a_data))
            $display("FAIL contention_commit[%0d]: reg_write=%b rd_addr=%0d rd_data=%h, required 1 %0d",
                     i, reg_write, rd_addr, rd_data, exp_b ? 7 : 3);
         else n_pass++;
      end
      tick();
      n_total++;
      if (reg_write !== 1'b0)
         $display("FAIL contention_idle: reg_write=%b, required 0", reg_write);
      else n_pass++;
   endtask

   task automatic test_scoreboard;
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0; rs1_addr = 5'd9;
      #1;
      n_total++;
      if (rs1_busy !== 1'b1) $display("FAIL sb_set: rs1_busy=%b, required 1", rs1_busy);
      else n_pass++;
      b_valid = 1'b1; b_rd = 5'd9; b_data = 64'hDEAD_BEEF_0000_0009;
      #1;
      n_total++;
      if (b_ready !== 1'b1 || rs1_busy !== 1'b1)
         $display("FAIL sb_grant: b_ready=%b rs1_busy=%b, required 1 1", b_ready, rs1_busy);
      else n_pass++;
      tick();
      b_valid = 1'b0;
      n_total++;
      if (reg_write !== 1'b1 || rd_addr !== 5'd9 || rs1_busy !== 1'b1)
         $display("FAIL sb_commit: reg_write=%b rd_addr=%0d rs1_busy=%b, required 1 9 1",
                  reg_write, rd_addr, rs1_busy);
      else n_pass++;
      tick();
      n_total++;
      if (rs1_busy !== 1'b0 || reg_write !== 1'b0)
         $display("FAIL sb_clear: rs1_busy=%b reg_write=%b, required 0 0", rs1_busy, reg_write);
      else n_pass++;
   endtask

   task automatic test_collision;
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0;
      a_valid = 1'b1; a_rd = 5'd9; a_data = 64'h0000_0000_9999_0009;
      tick();
      a_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0; rs1_addr = 5'd9;
      #1;
      n_total++;
      if (rs1_busy !== 1'b1)
         $display("FAIL collision_set_wins: rs1_busy=%b, required 1", rs1_busy);
      else n_pass++;
      tick();
      n_total++;
      if (rs1_busy !== 1'b1 || reg_write !== 1'b0)
         $display("FAIL collision_hold: rs1_busy=%b reg_write=%b, required 1 0", rs1_busy, reg_write);
      else n_pass++;
   endtask

   task automatic test_x0_reset;
      do_reset();
      issue_valid = 1'b1; issue_rd = 5'd4;
      tick();
      issue_valid = 1'b0;
      a_valid = 1'b1; a_rd = 5'd0; a_data = 64'hFFFF_FFFF_FFFF_FFFF;
      rs1_addr = 5'd0; rs2_addr = 5'd4;
      #1;
      n_total++;
      if (a_ready !== 1'b1) $display("FAIL x0_ready: a_ready=%b, required 1", a_ready);
      else n_pass++;
      tick();
      a_valid = 1'b0;
      n_total++;
      if (reg_write !== 1'b0 || rs2_busy !== 1'b1 || rs1_busy !== 1'b0)
         $display("FAIL x0_nowrite: reg_write=%b busy4=%b busy0=%b, required 0 1 0",
                  reg_write, rs2_busy, rs1_busy);
      else n_pass++;
      a_valid = 1'b1; a_rd = 5'd6; a_data = 64'h0000_0000_0000_0066;
      tick();
      a_valid = 1'b0;
      n_total++;
      if (reg_write !== 1'b1)
         $display("FAIL midrst_pending: reg_write=%b, required 1", reg_write);
      else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_total++;
      if (reg_write !== 1'b0 || rs2_busy !== 1'b0)
         $display("FAIL midrst_async: reg_write=%b busy4=%b, required 0 0", reg_write, rs2_busy);
      else n_pass++;
      a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd1; b_rd = 5'd2;
      #1;
      n_total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0)
         $display("FAIL midrst_ready: a_ready=%b b_ready=%b, required 0 0", a_ready, b_ready);
      else n_pass++;
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0)
         $display("FAIL midrst_pointer: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
      else n_pass++;
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
   endtask

   task automatic test_random;
      bit exp_a, exp_b, acc_a, acc_b;
      int a_wait, b_wait, max_wait;
      logic [4:0]  g_rd;
      logic [63:0] g_data;
      do_reset();
      acc_a = 1'b0; acc_b = 1'b0; a_wait = 0; b_wait = 0; max_wait = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         // Sources keep their command stable until it is accepted.
         if (!(a_valid && !acc_a)) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_rd    = 5'($urandom_range(0, 31));
            a_data  = {$urandom, $urandom};
         end
         if (!(b_valid && !acc_b)) begin
            b_valid = ($urandom_range(0, 2) != 0);
            b_rd    = 5'($urandom_range(0, 31));
            b_data  = {$urandom, $urandom};
         end
         issue_valid = ($urandom_range(0, 1) != 0);
         issue_rd    = 5'($urandom_range(0, 31));
         rs1_addr    = 5'($urandom_range(0, 31));
         rs2_addr    = 5'($urandom_range(0, 31));
         #1;
         // Expected grant: lone requester wins, otherwise the one not served last.
         exp_a = a_valid && (!b_valid || m_last_b);
         exp_b = b_valid && (!a_valid || !m_last_b);
         n_total++;
         if (a_ready !== exp_a || b_ready !== exp_b)
            $display("FAIL rand_grant@%0d: a_ready=%b b_ready=%b, required %b %b",
                     cyc, a_ready, b_ready, exp_a, exp_b);
         else n_pass++;
         n_total++;
         if (rs1_busy !== m_busy[rs1_addr] || rs2_busy !== m_busy[rs2_addr])
            $display("FAIL rand_busy@%0d: rs1_busy=%b rs2_busy=%b, required %b %b",
                     cyc, rs1_busy, rs2_busy, m_busy[rs1_addr], m_busy[rs2_addr]);
         else n_pass++;
         a_wait = (a_valid && !exp_a) ? a_wait + 1 : 0;
         b_wait = (b_valid && !exp_b) ? b_wait + 1 : 0;
         if (a_wait > max_wait) max_wait = a_wait;
         if (b_wait > max_wait) max_wait = b_wait;
         // Model the edge: commit clears, then issue marks the new producer.
         if (m_wr) m_busy[m_addr] = 1'b0;
         if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
         acc_a = exp_a; acc_b = exp_b;
         m_wr = 1'b0;
         if (acc_a || acc_b) begin
            m_last_b = acc_b;
            g_rd   = acc_b ? b_rd : a_rd;
            g_data = acc_b ? b_data : a_data;
            if (g_rd != 5'd0) begin
               m_wr = 1'b1; m_addr = g_rd; m_data = g_data;
            end
         end
         tick();
         n_total++;
         if (reg_write !== m_wr || rd_addr !== m_addr || rd_data !== m_data)
            $display("FAIL rand_out@%0d: reg_write=%b rd_addr=%0d rd_data=%h, required %b %0d %h",
                     cyc, reg_write, rd_addr, rd_data, m_wr, m_addr, m_data);
         else n_pass++;
      end
      a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
      n_total++;
      if (max_wait > 1)
         $display("FAIL rand_fairness: longest wait %0d cycles, required at most 1", max_wait);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_scoreboard();
      test_collision();
      test_x0_reset();
      test_random();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32 x 64-bit integer register file between two writeback sources: A (ALU, single-cycle) and B (load/multi-cycle unit).
- Performs round-robin arbitration over valid/ready handshakes and drives a registered write command (reg_write/rd_addr/rd_data) into the register file.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.

Parameters:
- XLEN, 64, data width of write data and register file entries.
- REG_ADDR_W, 5, register address width; the register count is 2**REG_ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  source A has a write pending.
- a_ready  output  1  source A write accepted this cycle.
- a_rd  input  REG_ADDR_W  source A destination register.
- a_data  input  XLEN  source A write data.
- b_valid  input  1  source B has a write pending.
- b_ready  output  1  source B write accepted this cycle.
- b_rd  input  REG_ADDR_W  source B destination register.
- b_data  input  XLEN  source B write data.
- issue_valid  input  1  an instruction with a destination register issues this cycle.
- issue_rd  input  REG_ADDR_W  destination of the issuing instruction.
- rs1_addr  input  REG_ADDR_W  first source register query.
- rs2_addr  input  REG_ADDR_W  second source register query.
- rs1_busy  output  1  rs1_addr has an outstanding write.
- rs2_busy  output  1  rs2_addr has an outstanding write.
- reg_write  output  1  register file write enable.
- rd_addr  output  REG_ADDR_W  register file write address.
- rd_data  output  XLEN  register file write data.

Behaviour:
- Reset (asynchronous, active-high) values:
  - reg_write=0, rd_addr=0, rd_data=0.
  - All busy bits=0.
  - Last-grant pointer=B, so A wins the first contention.
- Arbitration (combinational):
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> grant the source not granted most recently.
  - At most one ready is high per cycle. ready never depends on the other source's ready.
  - While rst is high, both readies are 0.
- Last-grant pointer updates on every accepted transfer, contended or not.
- Handshake: a transfer completes on a rising edge when valid && ready. Sources hold rd and data stable while valid && !ready.
- Output stage, one-cycle latency:
  - On an accepted transfer with rd != 0: reg_write<=1, rd_addr<=granted rd, rd_data<=granted data.
  - Otherwise reg_write<=0; rd_addr and rd_data hold their last values.
- x0 writes: the handshake completes (ready=1) but reg_write stays 0 and the scoreboard is untouched.
- Scoreboard, busy[1..31]; busy[0] is constant 0:
  - Set on issue_valid && issue_rd != 0.
  - Cleared on an edge where reg_write=1, for busy[rd_addr]. This is the same edge the register file commits.
  - Set and clear of the same register on the same edge -> set wins, because a new producer is in flight.
  - Set and clear of different registers on the same edge -> both take effect.
- Queries are combinational: rs1_busy=busy[rs1_addr], rs2_busy=busy[rs2_addr]. Address 0 always returns 0.
- Throughput: one write per cycle sustained. Under continuous contention, A and B strictly alternate.
- No buffering: a source that is not granted simply waits. Each source is guaranteed a grant within 2 cycles of asserting valid.
- Reset asserted mid-operation:
  - The pending output write is dropped (reg_write forced to 0 immediately).
  - All busy bits clear.
  - The pointer returns to B.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: on each edge where reg_write=1, the simulation prints "WB commit: x<rd_addr> = <rd_data hex> (src A|B)". The source tag is registered alongside rd_addr.
- Not defined: no display statements and no source-tag register. Functional behaviour is identical in both cases.

Test Plan:
- Reset: rst=1 then 0 -> reg_write=0, rs1_busy=0 for every rs1_addr, a_ready=b_ready=0 while rst=1.
- Single source: a_valid=1, a_rd=5, a_data=0x1234 for one cycle -> a_ready=1; next cycle reg_write=1, rd_addr=5, rd_data=0x1234; following cycle reg_write=0.
- Contention: a_valid=b_valid=1 for 4 cycles (A: rd=3, B: rd=7, distinct data) -> grants A,B,A,B; committed rd_addr sequence 3,7,3,7, each one cycle after its grant.
- Scoreboard: issue_valid rd=9 -> rs1_busy=1 for rs1_addr=9 next cycle; B writes rd=9 -> busy stays 1 through the grant cycle, clears after the reg_write=1 edge.
- Set/clear collision: commit of rd=9 and issue_valid rd=9 on the same edge -> rs1_busy for 9 remains 1.
- x0 and mid-op reset: a_valid rd=0 -> a_ready=1, reg_write stays 0, busy unchanged. Then with busy[4]=1 and a commit pending, assert rst -> reg_write=0 immediately and busy[4]=0.
